// File: rtl/instr_pkg.sv
// Opcode constants, instruction field positions and the word-encoding helpers
// shared by the instruction encoder.
package instr_pkg;

    localparam logic [3:0] OP_LD   = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0001;
    localparam logic [3:0] OP_JMP  = 4'b0010;
    localparam logic [3:0] OP_BZ   = 4'b0100;
    localparam logic [3:0] OP_ALU  = 4'b1000;
    localparam logic [3:0] OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_SUBI = 4'b1101;
    localparam logic [3:0] OP_ANDI = 4'b1110;
    localparam logic [3:0] OP_ORI  = 4'b1111;

    localparam int OP_LSB = 12;
    localparam int RI_LSB = 10;
    localparam int RJ_LSB = 8;
    localparam int WORD_W = 16;

    // Jumps carry a 12-bit target, ALU ops carry func, everything else an 8-bit immediate.
    function automatic logic [15:0] encode_word(input logic [3:0]  op,
                                                input logic [1:0]  ri,
                                                input logic [1:0]  rj,
                                                input logic [7:0]  func,
                                                input logic [11:0] imm);
        logic [15:0] w;
        case (op)
            OP_JMP, OP_BZ: w = {op, imm};
            OP_ALU:        w = {op, ri, rj, func};
            default:       w = {op, ri, rj, imm[7:0]};
        endcase
        return w;
    endfunction

    function automatic logic is_legal(input logic [3:0] op, input logic [7:0] func);
        logic ok;
        case (op)
            OP_LD, OP_ST, OP_JMP, OP_BZ,
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: ok = 1'b1;
            OP_ALU:                            ok = (func != 8'h00);
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// DEPTH x W circular buffer with push, pop, flush and occupancy count.
// Flush wins over push and pop; push when full and pop when empty are ignored.
module encoder_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   cnt_r;
    logic          push_s;
    logic          pop_s;

    assign empty  = (cnt_r == '0);
    assign full   = (cnt_r == (PW+1)'(DEPTH));
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign rdata  = mem_r[rd_ptr_r];
    assign cnt    = cnt_r;

    // Storage, pointers and count; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + (PW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (PW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into 16-bit words, buffers them and drains them to
// sequential instruction-memory addresses. Define ILLEGAL_CHECK_EN to drop illegal requests.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     base_load,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_op,
    input  logic [1:0]               req_ri,
    input  logic [1:0]               req_rj,
    input  logic [7:0]               req_func,
    input  logic [11:0]              req_imm,
    input  logic                     im_ready,
    output logic                     im_we,
    output logic [ADDR_W-1:0]        im_addr,
    output logic [15:0]              im_wdata,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
`ifdef ILLEGAL_CHECK_EN
    output logic                     err_sticky,
    output logic [7:0]               err_count,
`endif
    output logic                     wrapped
);
    logic              full_s;
    logic              empty_s;
    logic              legal_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic [15:0]       word_s;
    logic [15:0]       head_s;
    logic [15:0]       last_word_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wrapped_r;

    // Request handshake, legality and drain control.
    always_comb begin
        word_s    = encode_word(req_op, req_ri, req_rj, req_func, req_imm);
`ifdef ILLEGAL_CHECK_EN
        legal_s   = is_legal(req_op, req_func);
`else
        legal_s   = 1'b1;
`endif
        req_ready = ~full_s & ~base_load;
        accept_s  = req_valid & req_ready;
        push_s    = accept_s & legal_s;
        im_we     = ~empty_s;
        pop_s     = ~empty_s & im_ready & ~base_load;
    end

    encoder_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (base_load),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (word_s),
        .rdata (head_s),
        .empty (empty_s),
        .full  (full_s),
        .cnt   (fifo_cnt)
    );

    assign im_addr  = addr_r;
    assign im_wdata = empty_s ? last_word_r : head_s;
    assign wrapped  = wrapped_r;

    // Write address, wrap flag and the word shown while the buffer is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r      <= '0;
            wrapped_r   <= 1'b0;
            last_word_r <= 16'h0000;
        end else if (base_load) begin
            addr_r      <= base_addr;
            wrapped_r   <= 1'b0;
        end else if (pop_s) begin
            addr_r      <= addr_r + ADDR_W'(1);
            last_word_r <= head_s;
            if (addr_r == '1) begin
                wrapped_r <= 1'b1;
            end
        end
    end

`ifdef ILLEGAL_CHECK_EN
    // Error flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky <= 1'b0;
            err_count  <= 8'h00;
        end else if (base_load) begin
            err_sticky <= 1'b0;
            err_count  <= 8'h00;
        end else if (accept_s && !legal_s) begin
            err_sticky <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'h01;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=4, ADDR_W=8).
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        base_load;
    logic [7:0]  base_addr;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [1:0]  req_ri;
    logic [1:0]  req_rj;
    logic [7:0]  req_func;
    logic [11:0] req_imm;
    logic        im_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [15:0] im_wdata;
    logic [2:0]  fifo_cnt;
    logic        wrapped;
`ifdef ILLEGAL_CHECK_EN
    logic        err_sticky;
    logic [7:0]  err_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .base_load (base_load),
        .base_addr (base_addr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_ri    (req_ri),
        .req_rj    (req_rj),
        .req_func  (req_func),
        .req_imm   (req_imm),
        .im_ready  (im_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .fifo_cnt  (fifo_cnt),
`ifdef ILLEGAL_CHECK_EN
        .err_sticky(err_sticky),
        .err_count (err_count),
`endif
        .wrapped   (wrapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [3:0] op, input logic [1:0] ri,
                           input logic [1:0] rj, input logic [7:0] fn, input logic [11:0] imm);
        req_valid = v;
        req_op    = op;
        req_ri    = ri;
        req_rj    = rj;
        req_func  = fn;
        req_imm   = imm;
    endtask

    initial begin
        rst = 1'b0; base_load = 1'b0; base_addr = 8'h00; im_ready = 1'b0;
        set_req(1'b0, 4'h0, 2'd0, 2'd0, 8'h00, 12'h000);
        #2;
        chk("rst_we", 32'(im_we), 32'd0);
        chk("rst_addr", 32'(im_addr), 32'h0);
        chk("rst_wdata", 32'(im_wdata), 32'h0);
        chk("rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_wrapped", 32'(wrapped), 32'd0);
`ifdef ILLEGAL_CHECK_EN
        chk("rst_errcnt", 32'(err_count), 32'd0);
        chk("rst_errst", 32'(err_sticky), 32'd0);
`endif
        #11 rst = 1'b1;
        tick();

        // 1: base 0x10, single ADDI
        base_load = 1'b1; base_addr = 8'h10;
        #1 chk("t1_ready_bl", 32'(req_ready), 32'd0);
        tick();
        base_load = 1'b0;
        chk("t1_base", 32'(im_addr), 32'h10);
        set_req(1'b1, 4'b1100, 2'd1, 2'd2, 8'h00, 12'h005);
        im_ready = 1'b1;
        #1 chk("t1_ready", 32'(req_ready), 32'd1);
        chk("t1_we_pre", 32'(im_we), 32'd0);
        tick();
        req_valid = 1'b0;
        #1 chk("t1_we", 32'(im_we), 32'd1);
        chk("t1_addr", 32'(im_addr), 32'h10);
        chk("t1_wdata", 32'(im_wdata), 32'hC605);
        chk("t1_cnt", 32'(fifo_cnt), 32'd1);
        tick();
        chk("t1_addr_inc", 32'(im_addr), 32'h11);
        chk("t1_empty_we", 32'(im_we), 32'd0);
        chk("t1_hold", 32'(im_wdata), 32'hC605);

        // 2: ALU then JMP back to back, drained at full rate
        set_req(1'b1, 4'b1000, 2'd3, 2'd0, 8'h04, 12'h000);
        tick();
        set_req(1'b1, 4'b0010, 2'd0, 2'd0, 8'h00, 12'hABC);
        #1 chk("t2_alu", 32'(im_wdata), 32'h8C04);
        chk("t2_alu_addr", 32'(im_addr), 32'h11);
        tick();
        req_valid = 1'b0;
        #1 chk("t2_jmp", 32'(im_wdata), 32'h2ABC);
        chk("t2_jmp_addr", 32'(im_addr), 32'h12);
        chk("t2_cnt", 32'(fifo_cnt), 32'd1);
        tick();
        chk("t2_done_cnt", 32'(fifo_cnt), 32'd0);
        chk("t2_done_addr", 32'(im_addr), 32'h13);

        // 3: fill while memory stalls, then drain in order
        im_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 4'b1100, 2'd0, 2'd1, 8'h00, 12'(i));
            tick();
        end
        chk("t3_full_cnt", 32'(fifo_cnt), 32'd4);
        chk("t3_full_ready", 32'(req_ready), 32'd0);
        set_req(1'b1, 4'b1100, 2'd0, 2'd1, 8'h00, 12'h004);
        tick();
        chk("t3_stall_cnt", 32'(fifo_cnt), 32'd4);
        req_valid = 1'b0;
        im_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t3_we", 32'(im_we), 32'd1);
            chk("t3_wdata", 32'(im_wdata), 32'hC100 + 32'(i));
            chk("t3_addr", 32'(im_addr), 32'h13 + 32'(i));
            tick();
        end
        chk("t3_empty", 32'(im_we), 32'd0);
        chk("t3_end_addr", 32'(im_addr), 32'h17);

        // 4: address wrap
        base_load = 1'b1; base_addr = 8'hFE; im_ready = 1'b0;
        tick();
        base_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 4'b1111, 2'd2, 2'd3, 8'h00, 12'h030 + 12'(i));
            tick();
        end
        req_valid = 1'b0;
        im_ready = 1'b1;
        #1 chk("t4_a0", 32'(im_addr), 32'hFE);
        chk("t4_w0", 32'(im_wdata), 32'hFB30);
        chk("t4_wr0", 32'(wrapped), 32'd0);
        tick();
        chk("t4_a1", 32'(im_addr), 32'hFF);
        chk("t4_wr1", 32'(wrapped), 32'd0);
        tick();
        chk("t4_a2", 32'(im_addr), 32'h00);
        chk("t4_w2", 32'(im_wdata), 32'hFB32);
        chk("t4_wr2", 32'(wrapped), 32'd1);
        tick();
        chk("t4_cnt", 32'(fifo_cnt), 32'd0);
        chk("t4_wr3", 32'(wrapped), 32'd1);

        // 5: base_load mid-drain flushes and drops the in-flight pop
        im_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 4'b0000, 2'd1, 2'd1, 8'h00, 12'h011);
            tick();
        end
        req_valid = 1'b0;
        chk("t5_cnt3", 32'(fifo_cnt), 32'd3);
        base_load = 1'b1; base_addr = 8'h40; im_ready = 1'b1;
        tick();
        base_load = 1'b0;
        chk("t5_cnt0", 32'(fifo_cnt), 32'd0);
        chk("t5_we", 32'(im_we), 32'd0);
        chk("t5_addr", 32'(im_addr), 32'h40);
        chk("t5_wrapped", 32'(wrapped), 32'd0);

        // 6: illegal opcode and ALU with func=0
        im_ready = 1'b0;
        set_req(1'b1, 4'b0011, 2'd1, 2'd2, 8'h00, 12'h077);
        #1 chk("t6_ready", 32'(req_ready), 32'd1);
        tick();
        set_req(1'b1, 4'b1000, 2'd1, 2'd1, 8'h00, 12'h000);
        tick();
        req_valid = 1'b0;
`ifdef ILLEGAL_CHECK_EN
        chk("t6_cnt", 32'(fifo_cnt), 32'd0);
        chk("t6_we", 32'(im_we), 32'd0);
        chk("t6_errcnt", 32'(err_count), 32'd2);
        chk("t6_errst", 32'(err_sticky), 32'd1);
        base_load = 1'b1; base_addr = 8'h00;
        tick();
        base_load = 1'b0;
        chk("t6_errclr", 32'(err_count), 32'd0);
        chk("t6_stclr", 32'(err_sticky), 32'd0);
`else
        chk("t6_cnt", 32'(fifo_cnt), 32'd2);
        chk("t6_w0", 32'(im_wdata), 32'h3677);
        im_ready = 1'b1;
        tick();
        chk("t6_w1", 32'(im_wdata), 32'h8500);
        chk("t6_addr", 32'(im_addr), 32'h41);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
